// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundle between the FU array and the CDB arbiter.
//   master modport: FU side (drives requests/results, sees ack and the broadcast).
//   slave modport : arbiter side (sees requests/results, drives ack and the broadcast).
// Signals:
//   fu_done   [NUM_FU]        per-FU request, held until acked
//   fu_v      [NUM_FU*XLEN]   per-FU result, FU i at [i*XLEN +: XLEN]
//   fu_tag    [NUM_FU*TAG_W]  per-FU ROB tag, packed the same way
//   ack       [NUM_FU]        one-hot combinational grant
//   cdb_valid/cdb_v/cdb_tag/cdb_src  registered broadcast
`ifndef XLEN
`define XLEN 32
`endif

interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned XLEN   = `XLEN,
    parameter int unsigned TAG_W  = 5
);
    localparam int unsigned SRC_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]       fu_done;
    logic [NUM_FU*XLEN-1:0]  fu_v;
    logic [NUM_FU*TAG_W-1:0] fu_tag;
    logic [NUM_FU-1:0]       ack;
    logic                    cdb_valid;
    logic [XLEN-1:0]         cdb_v;
    logic [TAG_W-1:0]        cdb_tag;
    logic [SRC_W-1:0]        cdb_src;

    modport master (
        output fu_done, fu_v, fu_tag,
        input  ack, cdb_valid, cdb_v, cdb_tag, cdb_src
    );

    modport slave (
        input  fu_done, fu_v, fu_tag,
        output ack, cdb_valid, cdb_v, cdb_tag, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single Common Data Bus among NUM_FU functional units.
// Each cycle one requester (fu_done) receives a combinational one-hot ack; its value,
// tag and index are registered and broadcast on the CDB the following cycle.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   flush  branch-mispredict squash: suppresses ack and the next broadcast
//   bus    cdb_arbiter_if.slave (requests/results in, ack and broadcast out)
// Build option:
//   CDB_ARB_FIXED_PRI_EN  defined: lowest-index requester always wins (no pointer).
//                         undefined (default): round-robin from a rotating pointer.
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned XLEN   = `XLEN,
    parameter int unsigned TAG_W  = 5
) (
    input logic          clock,
    input logic          reset,
    input logic          flush,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned SRC_W = $clog2(NUM_FU);

    logic               grant_any;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand;
    logic [NUM_FU-1:0]  ack_d;
    logic [XLEN-1:0]    win_v;
    logic [TAG_W-1:0]   win_tag;

    logic               cdb_valid_q;
    logic [XLEN-1:0]    cdb_v_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [SRC_W-1:0]   cdb_src_q;

`ifdef CDB_ARB_FIXED_PRI_EN
    // Fixed priority: scan upward from index 0.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!reset && !flush) begin
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                cand = SRC_W'(k);
                if (!grant_any && bus.fu_done[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end
`else
    logic [SRC_W-1:0] ptr_q;
    logic [SRC_W-1:0] ptr_d;
    int unsigned      idx;

    // Round-robin: scan ptr, ptr+1, ... wrapping at NUM_FU (not at 2**SRC_W).
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        idx       = 0;
        if (!reset && !flush) begin
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= NUM_FU) begin
                    idx = idx - NUM_FU;
                end
                cand = SRC_W'(idx);
                if (!grant_any && bus.fu_done[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        ack_d   = '0;
        win_v   = bus.fu_v[32'(grant_idx) * XLEN +: XLEN];
        win_tag = bus.fu_tag[32'(grant_idx) * TAG_W +: TAG_W];
        if (grant_any) begin
            ack_d = NUM_FU'(1) << grant_idx;
        end
    end

    // Payload registers only load on a grant so the last broadcast stays visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_v_q     <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            cdb_valid_q <= grant_any;
            if (grant_any) begin
                cdb_v_q   <= win_v;
                cdb_tag_q <= win_tag;
                cdb_src_q <= grant_idx;
            end
        end
    end

    assign bus.ack       = ack_d;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_v     = cdb_v_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (NUM_FU=4, XLEN=32, TAG_W=5).
// Inputs change 1 time unit after the rising edge; ack is checked before the next edge,
// registered outputs are checked 1 time unit after it.
module tb_cdb_arbiter;
`ifdef CDB_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    cdb_arbiter_if #(.NUM_FU(4), .XLEN(32), .TAG_W(5)) bus ();

    cdb_arbiter #(.NUM_FU(4), .XLEN(32), .TAG_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        bus.fu_done = 4'b1111;
        bus.fu_v    = '0;
        bus.fu_tag  = '0;

        // Reset: ack held low regardless of requests, outputs cleared.
        tick();
        chk("reset_ack", 64'(bus.ack), 64'h0);
        tick();
        chk("reset_ack2", 64'(bus.ack), 64'h0);
        chk("reset_valid", 64'(bus.cdb_valid), 64'h0);
        chk("reset_v", 64'(bus.cdb_v), 64'h0);
        chk("reset_tag", 64'(bus.cdb_tag), 64'h0);
        chk("reset_src", 64'(bus.cdb_src), 64'h0);

        // Single request from FU2.
        reset            = 1'b0;
        bus.fu_done      = 4'b0100;
        bus.fu_v[64+:32] = 32'hDEAD_BEEF;
        bus.fu_tag[10+:5] = 5'd7;
        #2;
        chk("single_ack", 64'(bus.ack), 64'h4);
        tick();
        chk("single_valid", 64'(bus.cdb_valid), 64'h1);
        chk("single_v", 64'(bus.cdb_v), 64'hDEAD_BEEF);
        chk("single_tag", 64'(bus.cdb_tag), 64'd7);
        chk("single_src", 64'(bus.cdb_src), 64'd2);

        // Pointer now at 3: with everyone requesting, FU3 wins (FU0 under fixed priority).
        for (int i = 0; i < 4; i++) begin
            bus.fu_v[i*32+:32] = 32'h1000 + 32'(i);
            bus.fu_tag[i*5+:5] = 5'(10 + i);
        end
        bus.fu_done = 4'b1111;
        #2;
        chk("ptr3_ack", 64'(bus.ack), FIXED ? 64'h1 : 64'h8);
        tick();
        chk("ptr3_src", 64'(bus.cdb_src), FIXED ? 64'd0 : 64'd3);
        chk("ptr3_v", 64'(bus.cdb_v), FIXED ? 64'h1000 : 64'h1003);

        // All four request from reset, each dropping after its ack: grants 0,1,2,3.
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        bus.fu_done = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("all4_ack", 64'(bus.ack), 64'(4'b0001 << i));
            tick();
            bus.fu_done[i] = 1'b0;
            chk("all4_valid", 64'(bus.cdb_valid), 64'h1);
            chk("all4_src", 64'(bus.cdb_src), 64'(i));
            chk("all4_tag", 64'(bus.cdb_tag), 64'(10 + i));
        end
        #2;
        chk("all4_idle_ack", 64'(bus.ack), 64'h0);
        tick();
        chk("all4_end_valid", 64'(bus.cdb_valid), 64'h0);

        // Fairness: FU0 and FU1 request continuously (pointer back at 0).
        bus.fu_done = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            #2;
            chk("fair_ack", 64'(bus.ack), FIXED ? 64'h1 : ((k % 2 == 0) ? 64'h1 : 64'h2));
            tick();
            chk("fair_src", 64'(bus.cdb_src), FIXED ? 64'd0 : 64'(k % 2));
        end

        // Flush with everyone requesting: no ack, no broadcast, pointer unchanged (2).
        bus.fu_done = 4'b1111;
        flush       = 1'b1;
        #2;
        chk("flush_ack", 64'(bus.ack), 64'h0);
        tick();
        flush = 1'b0;
        chk("flush_valid", 64'(bus.cdb_valid), 64'h0);
        chk("flush_src_hold", 64'(bus.cdb_src), FIXED ? 64'd0 : 64'd1);
        #2;
        chk("postflush_ack", 64'(bus.ack), FIXED ? 64'h1 : 64'h4);
        tick();
        chk("postflush_valid", 64'(bus.cdb_valid), 64'h1);
        chk("postflush_src", 64'(bus.cdb_src), FIXED ? 64'd0 : 64'd2);

        // Reset mid-stream: grant FU1, then reset the following cycle.
        bus.fu_done = 4'b0010;
        #2;
        chk("mid_ack", 64'(bus.ack), 64'h2);
        tick();
        chk("mid_valid", 64'(bus.cdb_valid), 64'h1);
        reset       = 1'b1;
        bus.fu_done = 4'b1111;
        #2;
        chk("mid_reset_ack", 64'(bus.ack), 64'h0);
        tick();
        chk("mid_reset_valid", 64'(bus.cdb_valid), 64'h0);
        chk("mid_reset_v", 64'(bus.cdb_v), 64'h0);
        reset = 1'b0;
        #2;
        chk("mid_ptr0_ack", 64'(bus.ack), 64'h1);
        tick();
        bus.fu_done = 4'b0000;
        chk("mid_ptr0_src", 64'(bus.cdb_src), 64'd0);
        chk("mid_ptr0_v", 64'(bus.cdb_v), 64'h1000);

        // Idle: broadcast payload holds the last values.
        for (int k = 0; k < 10; k++) begin
            #2;
            chk("idle_ack", 64'(bus.ack), 64'h0);
            tick();
            chk("idle_valid", 64'(bus.cdb_valid), 64'h0);
            chk("idle_v", 64'(bus.cdb_v), 64'h1000);
            chk("idle_tag", 64'(bus.cdb_tag), 64'd10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus among NUM_FU functional units (mult_fu, ALU, load unit). Each FU holds its done flag and result until acknowledged. Each cycle the arbiter picks one requester, returns a one-cycle ack to it, and drives the registered CDB broadcast on the following cycle. It sits between the FU array and the ROB/RS wakeup logic in the pipeline.

## Interface
- NUM_FU, default 4: number of requesting FUs; must be at least 2.
- XLEN, default `XLEN: result width.
- TAG_W, default 5: ROB tag width.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  branch-mispredict squash; same-cycle effect, described below.
- fu_done  in  NUM_FU  per-FU request; high while that FU holds an unbroadcast result.
- fu_v  in  NUM_FU×XLEN  per-FU result value, packed, FU i at bits [i*XLEN +: XLEN].
- fu_tag  in  NUM_FU×TAG_W  per-FU ROB tag, packed the same way.
- ack  out  NUM_FU  one-hot grant, combinational from the current-cycle inputs and state.
- cdb_valid  out  1  registered: broadcast valid.
- cdb_v  out  XLEN  registered: broadcast value.
- cdb_tag  out  TAG_W  registered: broadcast ROB tag.
- cdb_src  out  $clog2(NUM_FU)  registered: index of the winning FU (debug).

## Operation
- State:
  - priority pointer ptr, range 0..NUM_FU-1.
  - Output registers cdb_valid, cdb_v, cdb_tag, cdb_src.
- Grant rule: the winner is the first i with fu_done[i]=1, scanning ptr, ptr+1, … mod NUM_FU.
  - At most one ack bit is high.
  - ack is all zero when no fu_done bit is set, or when flush=1.
- On grant to FU i at a rising edge:
  - ptr <= (i+1) mod NUM_FU.
  - cdb_valid <= 1; cdb_v <= fu_v[i]; cdb_tag <= fu_tag[i]; cdb_src <= i.
- No grant at a rising edge: cdb_valid <= 0. cdb_v, cdb_tag and cdb_src hold their values. ptr is unchanged.
- Requester contract:
  - The FU samples ack on the same edge and deasserts fu_done the next cycle.
  - If fu_done is still high the cycle after an ack, that is a new request; it is not a duplicate to suppress.
- flush: ack=0 and cdb_valid <= 0. ptr is unchanged. FUs discard their own state.
- Fairness: a requester that stays asserted waits at most NUM_FU-1 grants before it wins.
- The arbiter never asserts ack for an index whose fu_done=0.

## Timing
- Reset values: ptr=0, cdb_valid=0, cdb_v=0, cdb_tag=0, cdb_src=0. ack=0 while reset=1, regardless of fu_done.
- Latency from fu_done high (with a win) to ack: 0 cycles. ack is combinational.
- Latency from ack to cdb_valid: 1 cycle. The winner's value and tag are captured on the ack edge.
- Throughput: one broadcast per cycle. Back-to-back grants to different FUs give consecutive cdb_valid cycles.
- Simultaneous requests: exactly one is granted per cycle; the rest keep fu_done high and wait.
- Wrap-around: after granting index NUM_FU-1, ptr returns to 0.
- Reset mid-stream: a pending registered broadcast is dropped; cdb_valid=0 on the cycle after the reset edge.
- Same-cycle flush and requests: flush wins, so no ack and no broadcast.

## Configuration
- CDB_ARB_FIXED_PRI_EN:
  - Defined: ptr is removed and the lowest-index requesting FU always wins. Starvation is then possible, and is intended for the mult-latency isolation experiments.
  - Undefined (default): round-robin as described above.
- All other behaviour, including timing, reset values and flush handling, is identical in both builds.

## Test plan
- Single request: NUM_FU=4, fu_done=4'b0100, fu_v[2]=32'hDEAD_BEEF, fu_tag[2]=5'd7.
  - Expect ack=4'b0100 the same cycle.
  - Next cycle: cdb_valid=1, cdb_v=32'hDEAD_BEEF, cdb_tag=7, cdb_src=2, ptr=3.
- All four FUs request from reset, each dropping fu_done after its ack.
  - Expect grants in order 0,1,2,3 on four consecutive cycles, with cdb_valid high for four cycles then 0.
- Fairness: FU0 and FU1 hold fu_done high continuously, re-requesting after each ack.
  - Expect ack alternating 4'b0001, 4'b0010, 4'b0001, and so on.
  - With CDB_ARB_FIXED_PRI_EN defined, expect ack=4'b0001 every cycle.
- Flush: fu_done=4'b1111 with flush=1 for one cycle.
  - Expect ack=0, cdb_valid=0 the next cycle, and ptr unchanged.
- Reset mid-stream: grant FU1, then assert reset on the following cycle.
  - Expect cdb_valid=0, ptr=0, and ack=0 while reset=1.
- Idle: fu_done=0 for 10 cycles.
  - Expect ack=0, cdb_valid=0, and cdb_v/cdb_tag holding their last broadcast values.
